// File: rtl/cfg_lut_array.sv
// cfg_lut_array: CH registered K-input LUTs reprogrammed through a shadowed serial load.
// Optional CFG_LUT_READBACK_EN adds cfg_rdata_o, shifting the old table out while the new one shifts in.
module cfg_lut_array #(
  parameter int K = 4,
  parameter int CH = 2,
  parameter logic [CH*(1<<K)-1:0] INIT = '0
) (
  input  logic            clk_i,
  input  logic            rst_n_i,
  input  logic [CH*K-1:0] lut_in_i,
  output logic [CH-1:0]   lut_out_o,
  input  logic            cfg_start_i,
  input  logic            cfg_abort_i,
  input  logic            cfg_valid_i,
  input  logic            cfg_data_i,
  output logic            cfg_ready_o,
  output logic            cfg_busy_o,
  output logic            cfg_done_o
`ifdef CFG_LUT_READBACK_EN
  ,
  output logic            cfg_rdata_o
`endif
);
  localparam int TD = 1 << K;
  localparam int TOT = CH * TD;
  localparam int CW = $clog2(TOT + 1);
  typedef enum logic [1:0] {IDLE, SHIFT, COMMIT} state_t;
  state_t state;
  logic [TOT-1:0] active, shadow;
  logic [CW-1:0] cnt;
  logic [CH-1:0] lut_nxt;
  logic xfer;
  genvar c;
  for (c = 0; c < CH; c++) begin : g_ch
    logic [TD-1:0] tbl;
    assign tbl = active[c*TD +: TD];
    assign lut_nxt[c] = tbl[lut_in_i[c*K +: K]];
  end
  assign cfg_ready_o = state == SHIFT;
  assign cfg_busy_o = state != IDLE;
  assign cfg_done_o = state == COMMIT;
  assign xfer = cfg_valid_i & cfg_ready_o;
`ifdef CFG_LUT_READBACK_EN
  assign cfg_rdata_o = cfg_ready_o & shadow[TOT-1];
`endif
  always_ff @(posedge clk_i or negedge rst_n_i)
    if (!rst_n_i) begin
      state <= IDLE;
      active <= INIT;
      shadow <= '0;
      cnt <= '0;
      lut_out_o <= '0;
    end else begin
      lut_out_o <= lut_nxt;
      if (state == IDLE) begin
        if (cfg_start_i) begin
          state <= SHIFT;
          cnt <= '0;
`ifdef CFG_LUT_READBACK_EN
          shadow <= active;
`endif
        end
      end else if (state == SHIFT) begin
        // abort takes priority, so a final bit arriving with abort never commits
        if (cfg_abort_i) state <= IDLE;
        else if (xfer) begin
          shadow <= {shadow[TOT-2:0], cfg_data_i};
          cnt <= cnt + CW'(1);
          if (cnt == CW'(TOT - 1)) state <= COMMIT;
        end
      end else begin
        active <= shadow;
        state <= IDLE;
      end
    end
endmodule

// File: tb/tb_cfg_lut_array.sv
// tb_cfg_lut_array: vector-table and scoreboard bench for cfg_lut_array (K=4, CH=2).
module tb_cfg_lut_array;
  localparam logic [31:0] INIT = 32'h8000_FFFE;
  localparam logic [31:0] NEWT = 32'h6996_0001;
  logic clk = 0, rst_n = 0;
  logic [3:0] a0 = 0, a1 = 0;
  logic start = 0, abort = 0, valid = 0, data = 0;
  logic [1:0] lut_out;
  logic ready, busy, done;
  int n_chk = 0, n_fail = 0, done_cnt = 0;
  logic [1:0] sb[$];
  logic [31:0] cur_tab, pat;
  typedef struct {logic [31:0] tab; logic [3:0] a0; logic [3:0] a1; logic [1:0] exp;} vec_t;
  vec_t vecs[8];
`ifdef CFG_LUT_READBACK_EN
  logic rdata;
  logic [31:0] rb;
`endif
  cfg_lut_array #(.K(4), .CH(2), .INIT(INIT)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .lut_in_i({a1, a0}), .lut_out_o(lut_out),
    .cfg_start_i(start), .cfg_abort_i(abort), .cfg_valid_i(valid), .cfg_data_i(data),
    .cfg_ready_o(ready), .cfg_busy_o(busy), .cfg_done_o(done)
`ifdef CFG_LUT_READBACK_EN
    , .cfg_rdata_o(rdata)
`endif
  );
  always #5 clk = ~clk;
  always @(posedge clk) begin
    #1;
    if (done) done_cnt++;
  end
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, want completion");
    $fatal(1);
  end
  task check(input string nm, input logic [31:0] got, input logic [31:0] want);
    n_chk++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", nm, got, want);
    end
  endtask
  task cyc(input logic st, input logic ab, input logic vl, input logic dt);
    start = st; abort = ab; valid = vl; data = dt;
    sb.push_back({cur_tab[16 + a1], cur_tab[a0]});
    @(posedge clk);
    @(negedge clk);
    check("lut_out", lut_out, sb.pop_front());
  endtask
  task run_vecs(input logic [31:0] tab);
    for (int i = 0; i < 8; i++)
      if (vecs[i].tab == tab) begin
        a0 = vecs[i].a0; a1 = vecs[i].a1;
        cyc(0, 0, 0, 0);
        check("vec_lookup", lut_out, vecs[i].exp);
      end
    a0 = 0; a1 = 1;
  endtask
  task pulse_reset;
    start = 0; abort = 0; valid = 0; data = 0;
    #2 rst_n = 0;
    #1;
    check("rst_lut_out", lut_out, 0);
    check("rst_busy", busy, 0);
    check("rst_ready", ready, 0);
    check("rst_done", done, 0);
    @(negedge clk);
    rst_n = 1;
    cur_tab = INIT;
  endtask
  initial begin
    int nb, d0;
    vecs[0] = '{INIT, 4'h0, 4'hF, 2'b10};
    vecs[1] = '{INIT, 4'h5, 4'hE, 2'b01};
    vecs[2] = '{INIT, 4'h1, 4'h0, 2'b01};
    vecs[3] = '{INIT, 4'h8, 4'hF, 2'b11};
    vecs[4] = '{NEWT, 4'h0, 4'h3, 2'b01};
    vecs[5] = '{NEWT, 4'h5, 4'h1, 2'b10};
    vecs[6] = '{NEWT, 4'h0, 4'h7, 2'b11};
    vecs[7] = '{NEWT, 4'hF, 4'hF, 2'b00};
    cur_tab = INIT;
    pat = NEWT;
    repeat (2) @(negedge clk);
    check("reset_lut_out", lut_out, 0);
    check("reset_ready", ready, 0);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    rst_n = 1;
    // scenario 1: INIT lookups
    run_vecs(INIT);
    // scenario 4: abort after 17 bits, then abort with the final bit
    d0 = done_cnt;
    cyc(1, 0, 0, 0);
    for (int i = 0; i < 17; i++) cyc(0, 0, 1, pat[31 - i]);
    check("abort17_busy_pre", busy, 1);
    cyc(0, 1, 0, 0);
    check("abort17_busy", busy, 0);
    check("abort17_ready", ready, 0);
    cyc(1, 0, 0, 0);
    for (int i = 0; i < 31; i++) cyc(0, 0, 1, pat[31 - i]);
    cyc(0, 1, 1, pat[0]);
    check("abort_last_busy", busy, 0);
    check("abort_last_done", done, 0);
    cyc(0, 0, 0, 0);
    check("abort_no_done", done_cnt, d0);
    run_vecs(INIT);
    // scenario 2: contiguous load
    cyc(1, 0, 0, 0);
    check("start_busy", busy, 1);
    check("start_ready", ready, 1);
    for (int i = 0; i < 32; i++) begin
      cyc(0, 0, 1, pat[31 - i]);
      if (i == 30) check("done_early", done, 0);
    end
    check("done_pulse", done, 1);
    check("commit_ready", ready, 0);
    check("commit_busy", busy, 1);
    cyc(0, 0, 0, 0);
    check("done_one_cycle", done, 0);
    check("idle_busy", busy, 0);
    cur_tab = NEWT;
    cyc(0, 0, 0, 0);
    run_vecs(NEWT);
    // scenario 5: reset mid-load
    cyc(1, 0, 0, 0);
    for (int i = 0; i < 10; i++) cyc(0, 0, 1, pat[31 - i]);
    pulse_reset;
    cyc(0, 0, 0, 0);
    cyc(1, 0, 0, 0);
    check("post_reset_start", busy, 1);
    cyc(0, 1, 0, 0);
    check("post_reset_abort", busy, 0);
    run_vecs(INIT);
    // scenario 3: load with valid toggling
    d0 = done_cnt;
    cyc(1, 0, 0, 0);
    nb = busy ? 1 : 0;
    for (int i = 0; i < 64; i++) begin
      cyc(0, 0, i[0], pat[31 - i / 2]);
      nb += busy ? 1 : 0;
    end
    for (int j = 0; j < 10 && busy; j++) begin
      cyc(0, 0, 0, 0);
      nb += busy ? 1 : 0;
    end
    check("toggle_busy_cycles", nb, 65);
    check("toggle_done_cnt", done_cnt, d0 + 1);
    cur_tab = NEWT;
    run_vecs(NEWT);
`ifdef CFG_LUT_READBACK_EN
    // scenario 6: readback of INIT while loading zeros
    pulse_reset;
    cyc(1, 0, 0, 0);
    rb = 0;
    for (int i = 0; i < 32; i++) begin
      rb = {rb[30:0], rdata};
      cyc(0, 0, 1, 0);
    end
    check("readback", rb, INIT);
    check("rdata_commit", rdata, 0);
    cyc(0, 0, 0, 0);
    cur_tab = 0;
    for (int i = 0; i < 4; i++) begin
      a0 = 4'(i * 5); a1 = 4'(15 - i);
      cyc(0, 0, 0, 0);
      check("zero_table", lut_out, 0);
    end
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/cfg_lut_array.md
Name: cfg_lut_array

Overview:
- Array of CH independent K-input lookup tables.
- Each LUT output is registered.
- Truth tables load from the INIT parameter at reset. They are reprogrammed at run time through a serial bit-stream port.
- New contents go into a shadow register and are committed atomically, so a lookup never sees a partially loaded table.
- Serves as the reconfigurable glue-logic block for SoC control paths.

Parameters:
- K, 4, inputs per LUT (1..6); table depth per channel TD = 2^K.
- CH, 2, number of LUT channels; total table bits TOT = CH*TD.
- INIT, all zeros (width TOT), reset table contents; channel c = INIT[c*TD +: TD], entry index = channel address.

Ports:
- clk_i  in  1  clock; all state updates on rising edge.
- rst_n_i  in  1  asynchronous, active-low reset.
- lut_in_i  in  CH*K  channel c address = lut_in_i[c*K +: K]; bit 0 is the LSB (A input).
- lut_out_o  out  CH  registered lookup result per channel.
- cfg_start_i  in  1  request to begin a table load; honoured only in IDLE.
- cfg_abort_i  in  1  cancel a load in progress.
- cfg_valid_i  in  1  cfg_data_i holds a bit.
- cfg_data_i  in  1  serial table bit, MSB (bit TOT-1) first.
- cfg_ready_o  out  1  block accepts a bit this cycle.
- cfg_busy_o  out  1  high while not in IDLE.
- cfg_done_o  out  1  one-cycle pulse in the commit cycle.

Behaviour:
Reset (rst_n_i low, asynchronous):
- active table <= INIT; shadow <= 0; bit counter <= 0; state <= IDLE.
- lut_out_o, cfg_ready_o, cfg_busy_o, cfg_done_o all 0.
- Release is synchronous to clk_i.

Lookup:
- Every cycle, lut_out_o[c] <= active[c*TD + addr_c]; latency 1 cycle.
- Lookup runs in every state; during a load it uses the old table.

State IDLE:
- cfg_ready_o = 0.
- cfg_start_i = 1 -> SHIFT; counter <= 0.

State SHIFT:
- cfg_ready_o = 1, cfg_busy_o = 1.
- Transfer = cfg_valid_i & cfg_ready_o.
- On a transfer: shadow <= {shadow[TOT-2:0], cfg_data_i}; counter += 1.
- Counter width is clog2(TOT+1). Cycles with cfg_valid_i low leave shadow and counter unchanged.
- When the transfer bringing the counter to TOT is accepted -> COMMIT.
- cfg_abort_i = 1 -> IDLE; shadow is discarded and the active table is unchanged.
- Abort wins over a simultaneous final transfer.
- cfg_start_i is ignored in SHIFT.

State COMMIT (one cycle):
- cfg_ready_o = 0, cfg_busy_o = 1, cfg_done_o = 1.
- At the end-of-cycle edge: active <= shadow; state -> IDLE.
- cfg_abort_i is ignored here.
- The lookup registered at that same edge still uses the old table. The first lut_out_o value from the new table appears one cycle later.

Outputs:
- cfg_ready_o, cfg_busy_o and cfg_done_o are decoded from registered state only; there is no combinational path from inputs.

Reset mid-operation:
- Any state -> IDLE with the active table = INIT; a partial load is lost.

Optional Feature:
- Macro: CFG_LUT_READBACK_EN.
- Defined:
  - adds port cfg_rdata_o (out, 1), reset 0.
  - On IDLE->SHIFT, shadow <= active (not cleared).
  - cfg_rdata_o = shadow[TOT-1] whenever cfg_ready_o = 1, else 0.
  - Each accepted bit therefore shifts out the current table MSB-first while the new one shifts in.
  - Abort still leaves the active table unchanged.
- Undefined:
  - port cfg_rdata_o is absent.
  - shadow is not loaded on start; its contents before the first transfer are don't-care, since all TOT bits are overwritten before commit.

Test Plan:
Common setup for all scenarios: K=4, CH=2, INIT = 32'h8000_FFFE (ch0 = OR4, ch1 = AND4).

1. Release reset; drive ch0 addr 4'h0, then 4'h5; drive ch1 addr 4'hF, then 4'hE -> lut_out_o[0] = 0 then 1 and lut_out_o[1] = 1 then 0, each one cycle after its address.
2. Pulse start; shift 32'h6996_0001 MSB-first with valid held high 32 cycles -> cfg_done_o high exactly one cycle after the 32nd transfer. Then ch0 addr 0 -> 1 and ch1 addr 4'h3 -> 0. ch1 addr 4'h1 reads 1 only from the second cycle after done.
3. Same load with cfg_valid_i toggling every other cycle -> cfg_busy_o lasts 64+1 cycles and the final table is identical to scenario 2.
4. Start, 17 transfers, assert cfg_abort_i -> busy drops next cycle, cfg_done_o never pulses, and the table is still 32'h8000_FFFE. Also assert abort together with the 32nd bit -> no commit.
5. Start, 10 transfers, pulse rst_n_i low mid-cycle -> outputs 0 immediately; after release the table is INIT and a new cfg_start_i is accepted.
6. With CFG_LUT_READBACK_EN defined: start, shift 32 zeros -> cfg_rdata_o sequence equals 32'h8000_FFFE MSB-first; afterwards all lookups return 0.
